clk_div_sched: RTL and testbench

Run-time controller for an even-ratio clock divider. Generates one divided clock whose half-period (in clk cycles) is reprogrammed through a valid/ready config port. Ratio changes, starts and stops happen only on whole-period boundaries, so div_clk never has a truncated or stretched phase. Sits beside the fixed div2/div4/div6 dividers and drives blocks that need a software-selectable even ratio.

---
 rtl/clk_div_sched_pkg.sv | 18 +
 rtl/clk_div_phase_cnt.sv | 36 +++
 rtl/clk_div_sched.sv | 126 ++++++++++++
 tb/tb_clk_div_sched.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/clk_div_sched_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// clk_div_sched_pkg : shared types and constants for the even-ratio divider
// Rev 1.0
// ---------------------------------------------------------------------------
package clk_div_sched_pkg;

  localparam int HALF_W_DEF = 4;
  localparam int HALF_MAX   = (1 << HALF_W_DEF) - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/clk_div_phase_cnt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// clk_div_phase_cnt : loadable down-counter with registered terminal count
// Rev 1.0
// ---------------------------------------------------------------------------
module clk_div_phase_cnt #(
  parameter int HALF_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [HALF_W-1:0] i_load_val,
  output logic              o_tc
);

  logic [HALF_W-1:0] r_cnt;
  logic              r_tc;

  // r_tc is high exactly in the cycle the count reads zero; the count parks at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_tc  <= 1'b1;
    end else if (i_load) begin
      r_cnt <= i_load_val;
      r_tc  <= (i_load_val == '0);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - HALF_W'(1);
      r_tc  <= (r_cnt == HALF_W'(1));
    end
  end

  assign o_tc = r_tc;

endmodule
`default_nettype wire

// File: rtl/clk_div_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// clk_div_sched : run-time even-ratio clock divider, glitch-free ratio changes
// Rev 1.0
// ---------------------------------------------------------------------------
module clk_div_sched
  import clk_div_sched_pkg::*;
#(
  parameter int HALF_W       = HALF_W_DEF,
  parameter int DEFAULT_HALF = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [HALF_W-1:0] cfg_half,
  output logic              div_clk,
  output logic              period_start,
  output logic [HALF_W-1:0] active_half,
  output logic              cfg_err
);

  localparam logic [HALF_W-1:0] c_default_half = HALF_W'(DEFAULT_HALF);

  state_t            r_state;
  logic              r_div_clk;
  logic              r_period_start;
  logic              r_cfg_ready;
  logic              r_cfg_err;
  logic              r_pend_valid;
  logic [HALF_W-1:0] r_pend_half;
  logic [HALF_W-1:0] r_active_half;

  logic              w_tc;
  logic              w_accept;
  logic              w_cfg_ok;
  logic              w_start;
  logic              w_load;
  logic [HALF_W-1:0] w_next_half;
  logic [HALF_W-1:0] w_load_val;

  assign w_accept    = cfg_valid && r_cfg_ready;
  assign w_cfg_ok    = w_accept && (cfg_half != '0);
  assign w_next_half = r_pend_valid ? r_pend_half : r_active_half;
  // A new period begins from IDLE or from the last LOW cycle, only with run high.
  assign w_start     = run && ((r_state == ST_IDLE) || ((r_state == ST_LOW) && w_tc));
  assign w_load      = w_start || ((r_state == ST_HIGH) && w_tc);
  assign w_load_val  = (w_start ? w_next_half : r_active_half) - HALF_W'(1);

  clk_div_phase_cnt #(
    .HALF_W (HALF_W)
  ) u_phase_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_tc       (w_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_div_clk      <= 1'b0;
      r_period_start <= 1'b0;
      r_cfg_ready    <= 1'b1;
      r_cfg_err      <= 1'b0;
      r_pend_valid   <= 1'b0;
      r_pend_half    <= '0;
      r_active_half  <= c_default_half;
    end else begin
      r_period_start <= 1'b0;
      r_cfg_err      <= w_accept && (cfg_half == '0);
      // Ready stays low through the cycle in which the applied value first shows.
      r_cfg_ready    <= !(w_cfg_ok || r_pend_valid);

      case (r_state)
        ST_IDLE: begin
          if (run) begin
            r_state        <= ST_HIGH;
            r_div_clk      <= 1'b1;
            r_period_start <= 1'b1;
          end
        end
        ST_HIGH: begin
          if (w_tc) begin
            r_state   <= ST_LOW;
            r_div_clk <= 1'b0;
          end
        end
        ST_LOW: begin
          if (w_tc) begin
            if (run) begin
              r_state        <= ST_HIGH;
              r_div_clk      <= 1'b1;
              r_period_start <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_div_clk <= 1'b0;
        end
      endcase

      if (r_pend_valid && (w_start || (r_state == ST_IDLE))) begin
        r_active_half <= r_pend_half;
        r_pend_valid  <= 1'b0;
      end
      if (w_cfg_ok) begin
        r_pend_valid <= 1'b1;
        r_pend_half  <= cfg_half;
      end
    end
  end

  assign div_clk      = r_div_clk;
  assign period_start = r_period_start;
  assign active_half  = r_active_half;
  assign cfg_ready    = r_cfg_ready;
  assign cfg_err      = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_clk_div_sched : directed + random checks against a period-level model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_clk_div_sched;
  import clk_div_sched_pkg::*;

  localparam int HALF_W       = HALF_W_DEF;
  localparam int DEFAULT_HALF = 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              run;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [HALF_W-1:0] cfg_half;
  logic              div_clk;
  logic              period_start;
  logic [HALF_W-1:0] active_half;
  logic              cfg_err;

  int checks = 0;
  int errors = 0;

  // Model: a period of half h is 2h cycles long; div_clk is 1 for positions < h.
  bit m_running, m_pend, m_ready, m_err, m_ps;
  int m_pos, m_h, m_pend_h;

  clk_div_sched #(
    .HALF_W       (HALF_W),
    .DEFAULT_HALF (DEFAULT_HALF)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_half     (cfg_half),
    .div_clk      (div_clk),
    .period_start (period_start),
    .active_half  (active_half),
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_running = 0; m_pos = 0; m_h = DEFAULT_HALF;
    m_pend = 0; m_pend_h = 0; m_ready = 1; m_err = 0; m_ps = 0;
  endtask

  task automatic model_edge(input bit r, input bit v, input int h);
    bit acc, good, pend_old;
    acc      = v && m_ready;
    good     = acc && (h != 0);
    pend_old = m_pend;
    m_ps     = 0;
    if (!m_running) begin
      if (m_pend) begin m_h = m_pend_h; m_pend = 0; end
      if (r) begin m_running = 1; m_pos = 0; m_ps = 1; end
    end else if (m_pos == 2 * m_h - 1) begin
      if (r) begin
        if (m_pend) begin m_h = m_pend_h; m_pend = 0; end
        m_pos = 0; m_ps = 1;
      end else begin
        m_running = 0;
      end
    end else begin
      m_pos++;
    end
    m_err   = acc && (h == 0);
    m_ready = !(good || pend_old);
    if (good) begin m_pend = 1; m_pend_h = h; end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".div_clk"},      8'(div_clk),      8'(m_running && (m_pos < m_h)));
    chk({tag, ".period_start"}, 8'(period_start), 8'(m_ps));
    chk({tag, ".active_half"},  8'(active_half),  8'(m_h));
    chk({tag, ".cfg_ready"},    8'(cfg_ready),    8'(m_ready));
    chk({tag, ".cfg_err"},      8'(cfg_err),      8'(m_err));
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", tag);
  endtask

  task automatic step(input string tag, input bit r, input bit v, input int h);
    run = r; cfg_valid = v; cfg_half = HALF_W'(h);
    @(posedge clk);
    model_edge(r, v, h);
    @(negedge clk);
    check_all(tag);
  endtask

  // Hold cfg_valid until the model says the offer is taken.
  task automatic offer(input string tag, input bit r, input int h);
    int n = 0;
    while (!m_ready && n < 60) begin step(tag, r, 1, h); n++; end
    if (!m_ready) timeout(tag);
    step(tag, r, 1, h);
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; cfg_valid = 1'b0; cfg_half = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    reset = 1'b0;

    repeat (8) step("div2", 1, 0, 0);

    // Ratio change offered during the first HIGH cycle of a half=1 period
    for (int i = 0; i < 8 && !(m_running && m_pos == 0); i++) step("sync3", 1, 0, 0);
    step("cfg3", 1, 1, 3);
    repeat (16) step("div6", 1, 0, 0);

    step("cfg0", 1, 1, 0);
    repeat (6) step("after0", 1, 0, 0);

    // Run dropped in the first HIGH cycle of a half=2 period
    offer("cfg2", 1, 2);
    begin
      int n = 0;
      while (!(m_h == 2 && m_running && m_pos == 0) && n < 30) begin step("sync2", 1, 0, 0); n++; end
      if (n == 30) timeout("sync2");
    end
    repeat (8) step("rundrop", 0, 0, 0);
    repeat (8) step("restart", 1, 0, 0);

    // Async reset in the 2nd HIGH cycle with half=3 running and 5 pending
    offer("cfg3b", 1, 3);
    begin
      int n = 0;
      while (!(m_h == 3 && m_running && m_pos == 0 && m_ready) && n < 40) begin
        step("sync3b", 1, 0, 0); n++;
      end
      if (n == 40) timeout("sync3b");
    end
    step("cfg5", 1, 1, 5);
    cfg_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("async.div_clk",     8'(div_clk),     8'(0));
    chk("async.active_half", 8'(active_half), 8'(DEFAULT_HALF));
    chk("async.cfg_ready",   8'(cfg_ready),   8'(1));
    @(negedge clk);
    check_all("inreset");
    reset = 1'b0;
    repeat (12) step("postreset", 1, 0, 0);

    // Back-to-back configs with cfg_valid held
    offer("b2b2", 1, 2);
    offer("b2b4", 1, 4);
    repeat (24) step("b2bend", 1, 0, 0);

    // Config while stopped in IDLE
    begin
      int n = 0;
      while (m_running && n < 40) begin step("stop", 0, 0, 0); n++; end
      if (n == 40) timeout("stop");
    end
    step("idlecfg", 0, 1, 6);
    repeat (4) step("idlewait", 0, 0, 0);
    repeat (14) step("idlerun", 1, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      step("rand", ($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0),
           int'($urandom_range(0, HALF_MAX)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
